fetch_stage: RTL

Instruction-fetch stage of the single-issue CPU: holds the program counter, drives `instruction_memory`, and registers the returned word into the IF/ID pipeline register consumed by decode and `register_file`. It applies downstream stall and branch/jump redirect requests. It also contains the load-use interlock, which inserts bubbles after an `LD` so hand-placed NOPs are no longer required.

---
 rtl/cpu_pkg.sv | 44 ++++
 rtl/load_use_detector.sv | 39 +++
 rtl/fetch_stage.sv | 103 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU opcode constants, field positions and register-read helpers
//
// Purpose: single source of truth for instruction encoding, used by fetch and decode.
// Ports: none (package).

package cpu_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ST   = 4'h3,
    OP_ADD  = 4'h4,
    OP_INC  = 4'h5,
    OP_NEG  = 4'h6,
    OP_SUB  = 4'h7,
    OP_J    = 4'h8,
    OP_BRZ  = 4'h9,
    OP_JM   = 4'hA,
    OP_BRN  = 4'hB,
    OP_LD   = 4'hE,
    OP_SVPC = 4'hF
  } opcode_e;

  localparam int INSTR_W = 32;
  localparam int REG_W   = 6;
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 28;
  localparam int RD_MSB  = 27;
  localparam int RD_LSB  = 22;
  localparam int RS_MSB  = 21;
  localparam int RS_LSB  = 16;
  localparam int RT_MSB  = 15;
  localparam int RT_LSB  = 10;

  // Every opcode except NOP and SVPC uses rs as a source.
  function automatic logic reads_rs(input logic [3:0] op);
    return !((opcode_e'(op) == OP_NOP) || (opcode_e'(op) == OP_SVPC));
  endfunction

  // Only the two-source ALU ops and the store read rt.
  function automatic logic reads_rt(input logic [3:0] op);
    return (opcode_e'(op) == OP_ADD) || (opcode_e'(op) == OP_SUB) || (opcode_e'(op) == OP_ST);
  endfunction

endpackage

// File: rtl/load_use_detector.sv
// rtl/load_use_detector.sv - combinational load-use hazard detector
//
// Purpose: flags when the word coming back from instruction memory reads the
// destination of a recent LD while its bubble window is still open.
// Ports:
//   i_ld_rd      in  6   destination register of the most recent LD
//   i_ld_cnt     in  2   bubble slots still outstanding for that LD
//   i_instr      in  32  instruction word returned by instruction memory
//   o_interlock  out 1   insert a bubble this cycle

module load_use_detector
  import cpu_pkg::*;
(
  input  logic [REG_W-1:0]   i_ld_rd,
  input  logic [1:0]         i_ld_cnt,
  input  logic [INSTR_W-1:0] i_instr,
  output logic               o_interlock
);

  logic [3:0]       w_op;
  logic [REG_W-1:0] w_rs;
  logic [REG_W-1:0] w_rt;
  logic             w_rs_hit;
  logic             w_rt_hit;
  logic             w_unused_bits;

  assign w_op = i_instr[OPC_MSB:OPC_LSB];
  assign w_rs = i_instr[RS_MSB:RS_LSB];
  assign w_rt = i_instr[RT_MSB:RT_LSB];

  // rd and the immediate tail do not take part in hazard detection.
  assign w_unused_bits = ^{i_instr[RD_MSB:RD_LSB], i_instr[RT_LSB-1:0]};

  assign w_rs_hit = reads_rs(w_op) && (w_rs == i_ld_rd);
  assign w_rt_hit = reads_rt(w_op) && (w_rt == i_ld_rd);

  assign o_interlock = (i_ld_cnt != 2'd0) && (w_rs_hit || w_rt_hit);

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with PC, IF/ID register and load-use interlock
//
// Purpose: holds the PC, addresses instruction memory, registers the returned
// word into IF/ID, and applies redirect, stall and load-use bubbles.
// Ports:
//   i_clk              in  1         system clock
//   i_rst_n            in  1         asynchronous active-low reset
//   i_stall            in  1         freeze PC, IF/ID and interlock state
//   i_redirect_valid   in  1         taken branch/jump resolved downstream
//   i_redirect_target  in  PC_WIDTH  next PC on redirect
//   o_imem_addr        out PC_WIDTH  current PC
//   i_imem_instr       in  32        word returned for o_imem_addr
//   o_ifid_instr       out 32        registered instruction (0 when bubble)
//   o_ifid_pc          out PC_WIDTH  PC of o_ifid_instr
//   o_ifid_valid       out 1         o_ifid_instr is a real instruction
//   o_interlock        out 1         load-use bubble inserted this cycle

module fetch_stage
  import cpu_pkg::*;
#(
  parameter int                     PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0]    RESET_PC     = '0,
  parameter int                     LOAD_BUBBLES = 2
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_stall,
  input  logic                i_redirect_valid,
  input  logic [PC_WIDTH-1:0] i_redirect_target,
  output logic [PC_WIDTH-1:0] o_imem_addr,
  input  logic [INSTR_W-1:0]  i_imem_instr,
  output logic [INSTR_W-1:0]  o_ifid_instr,
  output logic [PC_WIDTH-1:0] o_ifid_pc,
  output logic                o_ifid_valid,
  output logic                o_interlock
);

  localparam logic [1:0] LB_CNT = 2'(LOAD_BUBBLES);

  logic [PC_WIDTH-1:0] r_pc;
  logic [INSTR_W-1:0]  r_ifid_instr;
  logic [PC_WIDTH-1:0] r_ifid_pc;
  logic                r_ifid_valid;
  logic [REG_W-1:0]    r_ld_rd;
  logic [1:0]          r_ld_cnt;

  logic                w_interlock;
  logic                w_fetch_is_ld;

  load_use_detector u_load_use_detector (
    .i_ld_rd     (r_ld_rd),
    .i_ld_cnt    (r_ld_cnt),
    .i_instr     (i_imem_instr),
    .o_interlock (w_interlock)
  );

  assign w_fetch_is_ld = (opcode_e'(i_imem_instr[OPC_MSB:OPC_LSB]) == OP_LD);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc         <= RESET_PC;
      r_ifid_instr <= '0;
      r_ifid_pc    <= '0;
      r_ifid_valid <= 1'b0;
      r_ld_rd      <= '0;
      r_ld_cnt     <= 2'd0;
    end else if (i_redirect_valid) begin
      // The word fetched from the old path is squashed; any pending load
      // window belongs to the wrong path and is dropped.
      r_pc         <= i_redirect_target;
      r_ifid_instr <= '0;
      r_ifid_pc    <= '0;
      r_ifid_valid <= 1'b0;
      r_ld_cnt     <= 2'd0;
    end else if (i_stall) begin
      // hold everything
    end else if (w_interlock) begin
      // Re-fetch the same PC next cycle; the bubble carries the stalled PC.
      r_ifid_instr <= '0;
      r_ifid_pc    <= r_pc;
      r_ifid_valid <= 1'b0;
      r_ld_cnt     <= r_ld_cnt - 2'd1;
    end else begin
      r_ifid_instr <= i_imem_instr;
      r_ifid_pc    <= r_pc;
      r_ifid_valid <= 1'b1;
      r_pc         <= r_pc + PC_WIDTH'(1);
      if (w_fetch_is_ld) begin
        r_ld_rd  <= i_imem_instr[RD_MSB:RD_LSB];
        r_ld_cnt <= LB_CNT;
      end else if (r_ld_cnt != 2'd0) begin
        r_ld_cnt <= r_ld_cnt - 2'd1;
      end
    end
  end

  assign o_imem_addr  = r_pc;
  assign o_ifid_instr = r_ifid_instr;
  assign o_ifid_pc    = r_ifid_pc;
  assign o_ifid_valid = r_ifid_valid;
  assign o_interlock  = w_interlock;

endmodule
